// File: rtl/io1bidir_pad_ctrl_pkg.sv
// Shared definitions for the single-bit bidirectional pad controller:
// mode encodings, controller states and config word field offsets.
package io_pad_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_IN   = 2'b01;
    localparam logic [1:0] MODE_OUT  = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    // Config word layout: [1:0] mode, [3:2] output track select.
    localparam int CFG_W        = 4;
    localparam int CFG_MODE_LSB = 0;
    localparam int CFG_SEL_LSB  = 2;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_IN,
        ST_OUT,
        ST_DRAIN
    } pad_state_e;

    // Requested mode to target state; the reserved encoding behaves as OFF.
    function automatic pad_state_e mode_to_state(input logic [1:0] m);
        case (m)
            MODE_IN:  return ST_IN;
            MODE_OUT: return ST_OUT;
            default:  return ST_OFF;
        endcase
    endfunction

    // State to externally reported mode; DRAIN reports OFF.
    function automatic logic [1:0] state_to_mode(input pad_state_e s);
        case (s)
            ST_IN:   return MODE_IN;
            ST_OUT:  return MODE_OUT;
            default: return MODE_OFF;
        endcase
    endfunction

endpackage

// File: rtl/io1bidir_pad_ctrl_if.sv
// Config bus between the IO tile and the pad controller: a valid/ready
// word transfer plus a one-cycle error pulse back to the requester.
interface io1bidir_pad_ctrl_if;
    import io_pad_pkg::*;

    logic             cfg_valid;
    logic [CFG_W-1:0] cfg_data;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (output cfg_valid, output cfg_data, input cfg_ready, input cfg_err);
    modport slave  (input cfg_valid, input cfg_data, output cfg_ready, output cfg_err);

endinterface

// File: rtl/io1bidir_pad_ctrl_io_sync2.sv
// Two-flop synchronizer for the asynchronous pad input; clocks every cycle
// regardless of pad mode so it is already settled when input mode starts.
module io_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the pad value through two flops; rst clears both.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking (<=) so q takes the pre-edge meta, giving two real stages.
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/io1bidir_pad_ctrl.sv
// Run-time sequencer for one bidirectional IO pad. Holds off/in/out mode and
// the output track select, forces a tristate turnaround whenever the pad
// leaves output mode, fans the synchronized pad value out to four tracks in
// input mode and drives the selected track onto the pad in output mode.
module io1bidir_pad_ctrl
    import io_pad_pkg::*;
#(
    parameter int unsigned TURNAROUND = 2   // tristate cycles after leaving OUT, 1..15
) (
    input  logic                      clk,
    input  logic                      rst,
    io1bidir_pad_ctrl_if.slave        cfg_bus,
    input  logic [3:0]                track_in,
    input  logic                      pad_in,
    output logic                      pad_out,
    output logic                      pad_oe,
    output logic                      pin_0,
    output logic                      pin_1,
    output logic                      pin_2,
    output logic                      pin_3,
    output logic [1:0]                mode
);

    localparam logic [3:0] DRAIN_LOAD = 4'(TURNAROUND);

    pad_state_e state, state_nxt;
    pad_state_e target, target_nxt;
    logic [3:0] drain_cnt, drain_cnt_nxt;
    logic [1:0] sel;
    logic [1:0] prime_cnt;
    logic       accept;
    logic [1:0] cfg_mode;
    logic [1:0] cfg_sel;
    pad_state_e req_state;
    logic       sync_q;
    logic       pin_val;

    assign cfg_mode  = cfg_bus.cfg_data[CFG_MODE_LSB +: 2];
    assign cfg_sel   = cfg_bus.cfg_data[CFG_SEL_LSB +: 2];
    assign req_state = mode_to_state(cfg_mode);

    // A word is only taken outside DRAIN; anything offered during DRAIN is simply not accepted.
    assign cfg_bus.cfg_ready = (state != ST_DRAIN);
    assign accept            = cfg_bus.cfg_valid && cfg_bus.cfg_ready;
    assign mode              = state_to_mode(state);

    io_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pad_in),
        .q   (sync_q)
    );

    // State register: controller state, turnaround counter and pending target.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_OFF;
            target    <= ST_OFF;
            drain_cnt <= 4'd0;
        end else begin
            state     <= state_nxt;
            target    <= target_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    // Next-state logic: leaving OUT for anything else goes through DRAIN first.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves one unassigned (no latch).
        state_nxt     = state;
        target_nxt    = target;
        drain_cnt_nxt = drain_cnt;
        case (state)
            ST_DRAIN: begin
                if (drain_cnt <= 4'd1) begin
                    state_nxt = target;
                end else begin
                    drain_cnt_nxt = drain_cnt - 4'd1;
                end
            end
            ST_OUT: begin
                if (accept && (req_state != ST_OUT)) begin
                    state_nxt     = ST_DRAIN;
                    target_nxt    = req_state;
                    drain_cnt_nxt = DRAIN_LOAD;
                end
            end
            default: begin
                if (accept) begin
                    state_nxt = req_state;
                end
            end
        endcase
    end

    // Datapath registers: track select, pad drive/enable, error pulse, input priming.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel       <= 2'd0;
            pad_oe    <= 1'b0;
            pad_out   <= 1'b0;
            prime_cnt <= 2'd0;
            cfg_bus.cfg_err <= 1'b0;
        end else begin
            if (accept) begin
                sel <= cfg_sel;
            end
            // Enable follows the next state so it changes together with state.
            pad_oe  <= (state_nxt == ST_OUT);
            pad_out <= (state == ST_OUT) ? track_in[sel] : 1'b0;
            cfg_bus.cfg_err <= accept && (cfg_mode == MODE_RSVD);
            // Count IN cycles up to 2; restart whenever IN is (re)entered or left.
            if ((state != ST_IN) || (state_nxt != ST_IN)) begin
                prime_cnt <= 2'd0;
            end else if (prime_cnt != 2'd2) begin
                prime_cnt <= prime_cnt + 2'd1;
            end
        end
    end

    assign pin_val = (state == ST_IN) && (prime_cnt == 2'd2) && sync_q;
    assign pin_0   = pin_val;
    assign pin_1   = pin_val;
    assign pin_2   = pin_val;
    assign pin_3   = pin_val;

endmodule

// File: tb/tb_io1bidir_pad_ctrl.sv
// Directed, table-driven bench for io1bidir_pad_ctrl. Each row gives the
// inputs held across one rising edge and the outputs expected just after it.
module tb_io1bidir_pad_ctrl;

    localparam int TA = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] track_in;
    logic       pad_in;
    logic       pad_out;
    logic       pad_oe;
    logic       pin_0, pin_1, pin_2, pin_3;
    logic [1:0] mode;

    io1bidir_pad_ctrl_if cfg_if ();

    io1bidir_pad_ctrl #(.TURNAROUND(TA)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_bus  (cfg_if.slave),
        .track_in (track_in),
        .pad_in   (pad_in),
        .pad_out  (pad_out),
        .pad_oe   (pad_oe),
        .pin_0    (pin_0),
        .pin_1    (pin_1),
        .pin_2    (pin_2),
        .pin_3    (pin_3),
        .mode     (mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       v;
        logic [3:0] data;
        logic [3:0] trk;
        logic       pin;
        logic       oe;
        logic       out;
        logic [3:0] pins;
        logic       rdy;
        logic       err;
        logic [1:0] mode;
    } vec_t;

    localparam int NVEC = 28;
    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [3:0] d,
                         input logic [3:0] t, input logic p);
        rst              = r;
        cfg_if.cfg_valid = v;
        cfg_if.cfg_data  = d;
        track_in         = t;
        pad_in           = p;
    endtask

    initial begin
        int drain;

        //            rst   v     data   trk    pin  | oe    out   pins   rdy   err   mode
        vecs[ 0] = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 2'b00}; // reset
        vecs[ 1] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 2'b00};
        vecs[ 2] = '{1'b0, 1'b1, 4'h1, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 2'b01}; // OFF->IN
        vecs[ 3] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 2'b01};
        vecs[ 4] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 2'b01}; // primed
        vecs[ 5] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 2'b01};
        vecs[ 6] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 2'b01}; // 2-cycle latency
        vecs[ 7] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 2'b01};
        vecs[ 8] = '{1'b0, 1'b1, 4'hA, 4'h4, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 2'b10}; // IN->OUT sel2
        vecs[ 9] = '{1'b0, 1'b0, 4'h0, 4'h4, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 2'b10};
        vecs[10] = '{1'b0, 1'b1, 4'h2, 4'h4, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 2'b10}; // OUT->OUT sel0
        vecs[11] = '{1'b0, 1'b0, 4'h0, 4'h4, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 2'b10};
        vecs[12] = '{1'b0, 1'b0, 4'h0, 4'h5, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 2'b10};
        vecs[13] = '{1'b0, 1'b1, 4'h1, 4'h5, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 2'b00}; // OUT->IN
        vecs[14] = '{1'b0, 1'b1, 4'h2, 4'h5, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 2'b00}; // dropped word
        vecs[15] = '{1'b0, 1'b0, 4'h0, 4'h5, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 2'b01};
        vecs[16] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 2'b01};
        vecs[17] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 2'b01};
        vecs[18] = '{1'b0, 1'b1, 4'h3, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 2'b00}; // reserved
        vecs[19] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 2'b00};
        vecs[20] = '{1'b0, 1'b1, 4'hE, 4'h8, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 2'b10}; // OFF->OUT sel3
        vecs[21] = '{1'b0, 1'b0, 4'h0, 4'h8, 1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 2'b10};
        vecs[22] = '{1'b0, 1'b1, 4'h1, 4'h8, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 2'b00}; // into DRAIN
        vecs[23] = '{1'b1, 1'b0, 4'h0, 4'h8, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 2'b00}; // rst mid-DRAIN
        vecs[24] = '{1'b0, 1'b0, 4'h0, 4'h8, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 2'b00};
        vecs[25] = '{1'b0, 1'b0, 4'h0, 4'h8, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 2'b00};
        vecs[26] = '{1'b1, 1'b1, 4'h2, 4'h8, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 2'b00}; // rst beats cfg
        vecs[27] = '{1'b0, 1'b0, 4'h0, 4'h8, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 2'b00};

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].v, vecs[i].data, vecs[i].trk, vecs[i].pin);
            @(posedge clk);
            #1;
            check($sformatf("row%0d_oe", i),   8'(pad_oe),           8'(vecs[i].oe));
            check($sformatf("row%0d_out", i),  8'(pad_out),          8'(vecs[i].out));
            check($sformatf("row%0d_pins", i), 8'({pin_3, pin_2, pin_1, pin_0}), 8'(vecs[i].pins));
            check($sformatf("row%0d_rdy", i),  8'(cfg_if.cfg_ready), 8'(vecs[i].rdy));
            check($sformatf("row%0d_err", i),  8'(cfg_if.cfg_err),   8'(vecs[i].err));
            check($sformatf("row%0d_mode", i), 8'(mode),             8'(vecs[i].mode));
        end

        // OFF->OUT, then OUT->OFF: ready must stay low for exactly TA cycles with oe low.
        drive(1'b0, 1'b1, 4'h2, 4'h0, 1'b0);
        @(posedge clk);
        #1;
        check("seq_out_oe", 8'(pad_oe), 8'd1);
        drive(1'b0, 1'b1, 4'h0, 4'h0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        drain = 0;
        while (!cfg_if.cfg_ready && drain < 20) begin
            check($sformatf("seq_drain%0d_oe", drain), 8'(pad_oe), 8'd0);
            drain++;
            @(posedge clk);
            #1;
        end
        check("seq_drain_len", 8'(drain), 8'(TA));
        check("seq_drain_mode", 8'(mode), 8'd0);
        check("seq_drain_oe_after", 8'(pad_oe), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
